// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding and datapath constants.
package mips_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise the entry becomes a bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               hold,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        valid    <= 1'b1;
        instr    <= load_instr;
        pc       <= load_pc;
        pc_plus4 <= load_pc + PC_INC;
      end else begin
        // Bubble keeps the payload so decode sees stable (but invalid) fields.
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, one-entry skid buffer and IF/ID.
// Handshake: imem_req is a one-cycle request always accepted; imem_rvalid/imem_rdata return it later.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [31:0]        fetch_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;
  logic               if_free;
  logic               rsp_wait;
  logic               issue;
  logic [31:0]        rsp_pc;
  logic               id_hold;
  logic               id_load;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;

  assign if_free  = !if_valid || !stall;
  assign rsp_wait = (state == WAIT) && imem_rvalid;
  // fetch_pc only advances on issue, so the outstanding request is one step behind it.
  assign rsp_pc   = fetch_pc - PC_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = WAIT;
      WAIT: begin
        if (imem_rvalid)   state_next = issue ? WAIT : IDLE;
        else if (redirect) state_next = DROP;
      end
      DROP: if (imem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    if (rst_n && !redirect && !skid_valid) begin
      case (state)
        IDLE:    issue = 1'b1;
        WAIT:    issue = imem_rvalid && if_free;
        default: issue = 1'b0;
      endcase
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= {redirect_pc[31:2], 2'b00};
    else if (issue)    fetch_pc <= fetch_pc + PC_INC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (redirect) begin
      skid_valid <= 1'b0;
    end else if (skid_valid && if_free) begin
      skid_valid <= 1'b0;
    end else if (rsp_wait && !if_free) begin
      skid_valid <= 1'b1;
      skid_instr <= imem_rdata;
      skid_pc    <= rsp_pc;
    end
  end

  assign id_hold  = stall && if_valid;
  assign id_load  = skid_valid || rsp_wait;
  assign id_instr = skid_valid ? skid_instr : imem_rdata;
  assign id_pc    = skid_valid ? skid_pc : rsp_pc;

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .hold       (id_hold),
    .load       (id_load),
    .load_instr (id_instr),
    .load_pc    (id_pc),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .pc_plus4   (if_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, per-cycle rule checker and directed scenarios.
module tb_fetch_stage;

  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        tie_lo = 1'b0;
  logic [31:0] tie_zero = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .stall(tie_lo),
    .redirect(tie_lo), .redirect_pc(tie_zero), .if_valid(w_valid),
    .if_instr(w_instr), .if_pc(w_pc), .if_pc_plus4(w_pc_plus4)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory models: main one answers after 'lat' cycles, wrap one after 1 cycle.
  initial begin : mem_model
    logic        busy;
    int          cnt;
    logic [31:0] addr;
    logic        w_pend;
    logic [31:0] w_a;
    busy = 1'b0; cnt = 0; addr = '0; w_pend = 1'b0; w_a = '0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      w_rvalid    = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
        w_pend = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = addr ^ KEY;
            busy        = 1'b0;
          end
        end
        if (w_pend) begin
          w_rvalid = 1'b1;
          w_rdata  = w_a ^ KEY;
        end
      end
      @(negedge clk);
      if (rst_n && imem_req) begin
        busy = 1'b1;
        cnt  = lat;
        addr = imem_addr;
      end
      w_pend = rst_n && w_req;
      w_a    = w_addr;
    end
  end

  // Rule model: request addresses follow the PC sequence, IF/ID delivers issued
  // right-path addresses in order, holds under stall, and empties on redirect.
  logic [31:0] model_pc = '0;
  logic [31:0] exp_q[$];
  logic        prev_redirect = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk) begin : compare
    logic [31:0] exp_pc;
    if (!rst_n) begin
      model_pc = 32'h0;
      exp_q.delete();
      prev_redirect = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_redirect) begin
        check("flush_valid", {31'b0, if_valid}, 32'd0);
      end else if (prev_hold) begin
        check("hold_valid", {31'b0, if_valid}, 32'd1);
        check("hold_pc", if_pc, prev_pc);
        check("hold_instr", if_instr, prev_instr);
      end else if (if_valid) begin
        exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : ~if_pc;
        check("model_if_pc", if_pc, exp_pc);
        check("model_if_instr", if_instr, exp_pc ^ KEY);
        check("model_if_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
      end
      if (imem_req) begin
        check("req_during_redirect", {31'b0, redirect}, 32'd0);
        check("model_imem_addr", imem_addr, model_pc);
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      if (redirect) begin
        model_pc = {redirect_pc[31:2], 2'b00};
        exp_q.delete();
      end
      prev_redirect = redirect;
      prev_hold     = stall && if_valid;
      prev_pc       = if_pc;
      prev_instr    = if_instr;
    end
  end

  // driver tasks
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clk); #1;
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs at once, releases; returns at negedge of cycle 0.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc_plus4", if_pc_plus4, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
  endtask

  initial begin : directed
    int nreq;
    int nval;
    // 1-cycle memory, plus the wrapping instance
    lat = 1;
    do_reset();
    check("wrap_c0", w_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, '0);
    check("c1_addr", imem_addr, 32'h4);
    check("c1_valid", {31'b0, if_valid}, 32'd0);
    check("wrap_c1", w_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    check("c2_addr", imem_addr, 32'h8);
    check("c2_valid", {31'b0, if_valid}, 32'd1);
    check("c2_pc", if_pc, 32'h0);
    check("c2_instr", if_instr, 32'hA5A5_0000);
    check("wrap_c2_req", {31'b0, w_req}, 32'd1);
    check("wrap_c2", w_addr, 32'h0);
    step(1'b0, 1'b0, '0);
    check("c3_pc", if_pc, 32'h4);
    check("c3_instr", if_instr, 32'hA5A5_0004);
    check("c3_pc_plus4", if_pc_plus4, 32'h8);
    repeat (6) step(1'b0, 1'b0, '0);

    // 3-cycle memory throughput
    lat = 3;
    repeat (6) step(1'b0, 1'b0, '0);
    nreq = 0;
    nval = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0);
      nreq += int'(imem_req);
      nval += int'(if_valid);
    end
    check("lat3_reqs", nreq, 32'd4);
    check("lat3_valids", nval, 32'd4);

    // stall for 4 cycles while if_pc = 8
    lat = 1;
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0);
      check("stall_pc", if_pc, 32'h8);
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    step(1'b0, 1'b0, '0);
    check("unstall_req", {31'b0, imem_req}, 32'd0);
    step(1'b0, 1'b0, '0);
    check("skid_pc", if_pc, 32'hC);
    check("skid_instr", if_instr, 32'hA5A5_000C);
    check("refetch_addr", imem_addr, 32'h10);
    step(1'b0, 1'b0, '0);
    check("post_skid_bubble", {31'b0, if_valid}, 32'd0);
    step(1'b0, 1'b0, '0);
    check("post_skid_pc", if_pc, 32'h10);

    // redirect while WAIT with no response
    lat = 3;
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_0103);
    check("redir_c4_valid", {31'b0, if_valid}, 32'd1);
    check("redir_c4_req", {31'b0, imem_req}, 32'd0);
    step(1'b0, 1'b0, '0);
    check("redir_bubble", {31'b0, if_valid}, 32'd0);
    check("redir_c5_req", {31'b0, imem_req}, 32'd0);
    step(1'b0, 1'b0, '0);
    check("redir_drop_req", {31'b0, imem_req}, 32'd0);
    check("redir_drop_valid", {31'b0, if_valid}, 32'd0);
    step(1'b0, 1'b0, '0);
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    repeat (4) step(1'b0, 1'b0, '0);
    check("redir_tgt_valid", {31'b0, if_valid}, 32'd1);
    check("redir_tgt_pc", if_pc, 32'h0000_0100);
    check("redir_tgt_instr", if_instr, 32'hA5A5_0100);

    // redirect together with stall
    lat = 1;
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_0200);
    check("rs_req", {31'b0, imem_req}, 32'd0);
    step(1'b0, 1'b0, '0);
    check("rs_valid", {31'b0, if_valid}, 32'd0);
    check("rs_addr", imem_addr, 32'h0000_0200);
    check("rs_req2", {31'b0, imem_req}, 32'd1);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("rs_tgt_pc", if_pc, 32'h0000_0200);
    check("rs_tgt_instr", if_instr, 32'hA5A5_0200);

    // reset mid-WAIT, then refetch from RESET_PC
    lat = 3;
    do_reset();
    repeat (7) step(1'b0, 1'b0, '0);
    check("pre_rst_pc", if_pc, 32'h4);
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    check("post_rst_valid", {31'b0, if_valid}, 32'd1);
    check("post_rst_pc", if_pc, 32'h0);

    repeat (2) step(1'b0, 1'b0, '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
